// File: rtl/vga_fb_scanout.sv
// VGA 640x480@60 scan-out of the 256x240 PPU frame buffer, pixels doubled 2x2 and centred
// between side borders. Counters form stage 0; every output appears three cycles later.
module vga_fb_scanout #(
   parameter int           H_ACTIVE     = 640,
   parameter int           H_FP         = 16,
   parameter int           H_SYNC       = 96,
   parameter int           H_BP         = 48,
   parameter int           V_ACTIVE     = 480,
   parameter int           V_FP         = 10,
   parameter int           V_SYNC       = 2,
   parameter int           V_BP         = 33,
   parameter int           H_OFFSET     = 64,
   parameter logic [7:0]   BORDER_COLOR = 8'h00
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   output logic [8:0]   fb_addr_row,
   output logic [8:0]   fb_addr_col,
   output logic         fb_read_en,
   input  logic [7:0]   fb_data,
   output logic [7:0]   vga_pixel,
   output logic         vga_hsync,
   output logic         vga_vsync,
   output logic         vga_active,
   output logic         vblank,
   output logic         frame_done
);

   localparam int         H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int         V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [9:0] WIN_FIRST = 10'(H_OFFSET);
   localparam logic [9:0] WIN_LAST  = 10'(H_OFFSET + 511);

   // Status bits: {hsync, vsync, active, vblank, frame_done}; idle pattern doubles as reset value.
   localparam logic [4:0] STAT_IDLE = 5'b11010;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t       state_reg, state_next;
   logic [9:0]   h_cnt_reg, h_cnt_next;
   logic [9:0]   v_cnt_reg, v_cnt_next;
   logic         end_of_frame;

   logic         s0_on;
   logic         s0_win;
   logic [9:0]   s0_col_off;
   logic [4:0]   s0_stat;

   logic         fb_read_en_reg;
   logic [8:0]   fb_addr_row_reg;
   logic [8:0]   fb_addr_col_reg;
   logic         win2_reg;
   logic [7:0]   pixel_reg;
   logic [4:0]   stat_reg [0:2];

   assign end_of_frame = (h_cnt_reg == H_LAST) && (v_cnt_reg == V_LAST);

   always_comb begin
      state_next = state_reg;
      h_cnt_next = h_cnt_reg;
      v_cnt_next = v_cnt_reg;
      case (state_reg)
         IDLE: begin
            h_cnt_next = '0;
            v_cnt_next = '0;
            if (enable) state_next = RUN;
         end
         RUN, DRAIN: begin
            if (h_cnt_reg == H_LAST) begin
               h_cnt_next = '0;
               v_cnt_next = (v_cnt_reg == V_LAST) ? 10'd0 : v_cnt_reg + 10'd1;
            end else begin
               h_cnt_next = h_cnt_reg + 10'd1;
            end
            // Leaving or re-entering DRAIN only changes where the frame may end, never the count.
            if (state_reg == RUN) begin
               if (!enable) state_next = end_of_frame ? IDLE : DRAIN;
            end else begin
               if (enable)            state_next = RUN;
               else if (end_of_frame) state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            h_cnt_next = '0;
            v_cnt_next = '0;
         end
      endcase
   end

   always_comb begin
      s0_on      = (state_reg != IDLE);
      s0_win     = s0_on && (v_cnt_reg < V_ACT) &&
                   (h_cnt_reg >= WIN_FIRST) && (h_cnt_reg <= WIN_LAST);
      s0_col_off = h_cnt_reg - WIN_FIRST;
      s0_stat    = {~(s0_on && (h_cnt_reg >= HS_FIRST) && (h_cnt_reg <= HS_LAST)),
                    ~(s0_on && (v_cnt_reg >= VS_FIRST) && (v_cnt_reg <= VS_LAST)),
                    s0_on && (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT),
                    ~s0_on || (v_cnt_reg >= V_ACT),
                    s0_on && end_of_frame};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         h_cnt_reg       <= '0;
         v_cnt_reg       <= '0;
         fb_read_en_reg  <= 1'b0;
         fb_addr_row_reg <= '0;
         fb_addr_col_reg <= '0;
         win2_reg        <= 1'b0;
         pixel_reg       <= BORDER_COLOR;
         for (int i = 0; i < 3; i++) stat_reg[i] <= STAT_IDLE;
      end else begin
         state_reg      <= state_next;
         h_cnt_reg      <= h_cnt_next;
         v_cnt_reg      <= v_cnt_next;
         fb_read_en_reg <= s0_win;
         // Halving row and column makes every frame buffer pixel cover a 2x2 VGA block.
         if (s0_win) begin
            fb_addr_row_reg <= v_cnt_reg[9:1];
            fb_addr_col_reg <= s0_col_off[9:1];
         end
         win2_reg  <= fb_read_en_reg;
         pixel_reg <= win2_reg ? fb_data : BORDER_COLOR;
         stat_reg[0] <= s0_stat;
         for (int i = 1; i < 3; i++) stat_reg[i] <= stat_reg[i-1];
      end
   end

   assign fb_read_en  = fb_read_en_reg;
   assign fb_addr_row = fb_addr_row_reg;
   assign fb_addr_col = fb_addr_col_reg;
   assign vga_pixel   = pixel_reg;
   assign vga_hsync   = stat_reg[2][4];
   assign vga_vsync   = stat_reg[2][3];
   assign vga_active  = stat_reg[2][2];
   assign vblank      = stat_reg[2][1];
   assign frame_done  = stat_reg[2][0];

endmodule
